// File: rtl/alu_operand_wb_stage_if.sv
// ============================================================================
// Module      : alu_operand_wb_stage_if
// Description : Decoder, ALU and debug signals of the operand/writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_operand_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  // decoder side
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        op_code;
  logic [ADDR_W-1:0] rdest;
  logic [ADDR_W-1:0] rsrc;
  logic [7:0]        imm;
  // ALU side
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [7:0]        alu_opcode;
  logic [DATA_W-1:0] alu_c;
  logic              alu_carry;
  logic              alu_flag;
  logic              alu_low;
  logic              alu_negative;
  logic              alu_zero;
  // status and debug
  logic [4:0]        psr;
  logic              done;
  logic              illegal;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output op_valid, op_code, rdest, rsrc, imm,
    output alu_c, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
    output dbg_addr,
    input  op_ready, alu_a, alu_b, alu_opcode, psr, done, illegal, dbg_data
  );

  modport slave (
    input  op_valid, op_code, rdest, rsrc, imm,
    input  alu_c, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
    input  dbg_addr,
    output op_ready, alu_a, alu_b, alu_opcode, psr, done, illegal, dbg_data
  );
endinterface

`default_nettype wire

// File: rtl/alu_operand_wb_stage.sv
// ============================================================================
// Module      : alu_operand_wb_stage
// Description : Register file, operand build and writeback/PSR stage around a
//               combinational ALU. Optional macro REGFILE_R0_ZERO_EN makes R0
//               a hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input wire clk,
  input wire reset,
  alu_operand_wb_stage_if.slave bus
);

  localparam int c_NREGS = 2 ** ADDR_W;

  localparam logic [7:0] c_OP_ADD    = 8'd0;
  localparam logic [7:0] c_OP_ADDU   = 8'd1;
  localparam logic [7:0] c_OP_ADDI   = 8'd2;
  localparam logic [7:0] c_OP_ADDUI  = 8'd3;
  localparam logic [7:0] c_OP_ADDC   = 8'd4;
  localparam logic [7:0] c_OP_ADDCU  = 8'd5;
  localparam logic [7:0] c_OP_ADDCUI = 8'd6;
  localparam logic [7:0] c_OP_ADDCI  = 8'd7;
  localparam logic [7:0] c_OP_SUB    = 8'd8;
  localparam logic [7:0] c_OP_SUBI   = 8'd9;
  localparam logic [7:0] c_OP_CMP    = 8'd10;
  localparam logic [7:0] c_OP_CMPU   = 8'd11;
  localparam logic [7:0] c_OP_CMPI   = 8'd12;
  localparam logic [7:0] c_OP_CMPUI  = 8'd13;
  localparam logic [7:0] c_OP_AND    = 8'd14;
  localparam logic [7:0] c_OP_OR     = 8'd15;
  localparam logic [7:0] c_OP_XOR    = 8'd16;
  localparam logic [7:0] c_OP_NOT    = 8'd17;
  localparam logic [7:0] c_OP_LSH    = 8'd18;
  localparam logic [7:0] c_OP_LSHI   = 8'd19;
  localparam logic [7:0] c_OP_RSH    = 8'd20;
  localparam logic [7:0] c_OP_RSHI   = 8'd21;
  localparam logic [7:0] c_OP_ALSH   = 8'd22;
  localparam logic [7:0] c_OP_ARSH   = 8'd23;
  localparam logic [7:0] c_OP_NOP    = 8'd24;

  // PSR layout {Zero,Negative,Low,Flag,Carry}
  localparam logic [4:0] c_PSR_C = 5'b00001;
  localparam logic [4:0] c_PSR_F = 5'b00010;
  localparam logic [4:0] c_PSR_L = 5'b00100;
  localparam logic [4:0] c_PSR_Z = 5'b10000;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit c_R0_ZERO = 1'b1;
`else
  localparam bit c_R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_op_ready;
  logic              w_accept;
  logic              w_capture;
  logic              w_retire;

  logic [DATA_W-1:0] r_regs [c_NREGS];
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [7:0]        r_alu_opcode;
  logic [ADDR_W-1:0] r_rdest;
  logic [DATA_W-1:0] r_c;
  logic [4:0]        r_flags;
  logic [4:0]        r_psr;
  logic              r_done;
  logic              r_illegal;

  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_dbg;
  logic              w_wr_allow;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;
  logic [DATA_W-1:0] w_opb;
  logic              w_wr_class;
  logic [4:0]        w_psr_mask;
  logic              w_bad_op;

  // Register-file read ports and the write filter for the optional zero R0
  generate
    if (c_R0_ZERO) begin : g_r0_zero
      assign w_rd_a     = (bus.rdest == '0)    ? '0 : r_regs[bus.rdest];
      assign w_rd_b     = (bus.rsrc == '0)     ? '0 : r_regs[bus.rsrc];
      assign w_dbg      = (bus.dbg_addr == '0) ? '0 : r_regs[bus.dbg_addr];
      assign w_wr_allow = (r_rdest != '0);
    end else begin : g_r0_plain
      assign w_rd_a     = r_regs[bus.rdest];
      assign w_rd_b     = r_regs[bus.rsrc];
      assign w_dbg      = r_regs[bus.dbg_addr];
      assign w_wr_allow = 1'b1;
    end
  endgenerate

  assign w_imm_sext = {{(DATA_W-8){bus.imm[7]}}, bus.imm};
  assign w_imm_zext = {{(DATA_W-8){1'b0}}, bus.imm};

  always_comb begin
    w_opb = w_rd_b;
    case (bus.op_code)
      c_OP_ADDI, c_OP_SUBI, c_OP_CMPI:
        w_opb = w_imm_sext;
      c_OP_ADDUI, c_OP_ADDCUI, c_OP_CMPUI, c_OP_LSHI, c_OP_RSHI:
        w_opb = w_imm_zext;
      default:
        w_opb = w_rd_b;
    endcase
  end

  // Writeback class of the op in flight
  always_comb begin
    w_wr_class = 1'b0;
    w_psr_mask = 5'b00000;
    w_bad_op   = 1'b0;
    case (r_alu_opcode)
      c_OP_ADD, c_OP_ADDI, c_OP_SUB, c_OP_SUBI, c_OP_ADDC: begin
        w_wr_class = 1'b1;
        w_psr_mask = c_PSR_F | c_PSR_Z;
      end
      c_OP_ADDU, c_OP_ADDUI, c_OP_ADDCU, c_OP_ADDCUI: begin
        w_wr_class = 1'b1;
        w_psr_mask = c_PSR_C | c_PSR_Z;
      end
      c_OP_CMP, c_OP_CMPU, c_OP_CMPI, c_OP_CMPUI: begin
        w_psr_mask = c_PSR_L;
      end
      c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_NOT, c_OP_LSH, c_OP_LSHI,
      c_OP_RSH, c_OP_RSHI, c_OP_ALSH, c_OP_ARSH: begin
        w_wr_class = 1'b1;
      end
      c_OP_NOP: begin
        w_wr_class = 1'b0;
      end
      c_OP_ADDCI: begin
        w_bad_op = 1'b1;
      end
      default: begin
        w_bad_op = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_ready  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_op_ready = 1'b1;
        if (bus.op_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        w_retire    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= c_OP_NOP;
      r_rdest      <= '0;
      r_c          <= '0;
      r_flags      <= '0;
      r_psr        <= '0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      // done/illegal are high for exactly the WB cycle
      r_done    <= w_capture;
      r_illegal <= w_capture & w_bad_op;
      if (w_accept) begin
        r_alu_a      <= w_rd_a;
        r_alu_b      <= w_opb;
        r_alu_opcode <= bus.op_code;
        r_rdest      <= bus.rdest;
      end
      if (w_capture) begin
        r_c     <= bus.alu_c;
        r_flags <= {bus.alu_zero, bus.alu_negative, bus.alu_low,
                    bus.alu_flag, bus.alu_carry};
      end
      if (w_retire) begin
        if (w_wr_class && w_wr_allow) begin
          r_regs[r_rdest] <= r_c;
        end
        r_psr <= (r_psr & ~w_psr_mask) | (r_flags & w_psr_mask);
      end
    end
  end

  assign bus.op_ready   = w_op_ready;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.psr        = r_psr;
  assign bus.done       = r_done;
  assign bus.illegal    = r_illegal;
  assign bus.dbg_data   = w_dbg;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_wb_stage.sv
// ============================================================================
// Module      : tb_alu_operand_wb_stage
// Description : Directed bench with a stub ALU and a retire-driven scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_wb_stage;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

`ifdef REGFILE_R0_ZERO_EN
  localparam logic [15:0] c_R0_NEW = 16'h0000;
`else
  localparam logic [15:0] c_R0_NEW = 16'h0005;
`endif

  typedef struct {
    logic [7:0]  op;
    logic        ill;
    logic [4:0]  psr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] old_v;
    logic [15:0] new_v;
    int          cyc;
  } exp_t;

  exp_t q[$];

  alu_operand_wb_stage_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  alu_operand_wb_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALU: arithmetic on A/B, Low is the compare result
  logic [16:0] m_t;
  logic [15:0] m_c;
  logic        m_carry, m_flag, m_low;
  always_comb begin
    m_t     = '0;
    m_c     = '0;
    m_carry = 1'b0;
    m_flag  = 1'b0;
    m_low   = 1'b0;
    if (bus.alu_opcode <= 8'd6) begin
      m_t     = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      m_c     = m_t[15:0];
      m_carry = m_t[16];
      m_flag  = (bus.alu_a[15] == bus.alu_b[15]) && (m_t[15] != bus.alu_a[15]);
    end else if (bus.alu_opcode >= 8'd8 && bus.alu_opcode <= 8'd13) begin
      m_t     = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      m_c     = m_t[15:0];
      m_carry = m_t[16];
      m_flag  = (bus.alu_a[15] != bus.alu_b[15]) && (m_t[15] != bus.alu_a[15]);
      if (bus.alu_opcode == 8'd11 || bus.alu_opcode == 8'd13)
        m_low = bus.alu_a < bus.alu_b;
      else
        m_low = $signed(bus.alu_a) < $signed(bus.alu_b);
    end else begin
      case (bus.alu_opcode)
        8'd14:        m_c = bus.alu_a & bus.alu_b;
        8'd15:        m_c = bus.alu_a | bus.alu_b;
        8'd16:        m_c = bus.alu_a ^ bus.alu_b;
        8'd17:        m_c = ~bus.alu_a;
        8'd18, 8'd19: m_c = bus.alu_a << bus.alu_b[3:0];
        8'd20, 8'd21: m_c = bus.alu_a >> bus.alu_b[3:0];
        8'd22:        m_c = bus.alu_a <<< bus.alu_b[3:0];
        8'd23:        m_c = 16'($signed(bus.alu_a) >>> bus.alu_b[3:0]);
        default:      m_c = 16'h0000;
      endcase
    end
  end

  assign bus.alu_c        = m_c;
  assign bus.alu_carry    = m_carry;
  assign bus.alu_flag     = m_flag;
  assign bus.alu_low      = m_low;
  assign bus.alu_negative = m_c[15];
  assign bus.alu_zero     = (m_c == 16'h0000);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (bus.op_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL %s: got op_ready=%b want 1 within 20 cycles", nm, bus.op_ready);
    end
  endtask

  // Present one op, record its expected retire, optionally keep op_valid
  // asserted (with different fields) through EXEC and WB.
  task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] im, input logic ill, input logic [4:0] psr,
                       input logic [15:0] b, input logic [15:0] old_v,
                       input logic [15:0] new_v, input int hold);
    exp_t e;
    @(negedge clk);
    bus.op_code  = op;
    bus.rdest    = rd;
    bus.rsrc     = rs;
    bus.imm      = im;
    bus.dbg_addr = rd;
    bus.op_valid = 1'b1;
    wait_ready("accept_wait");
    e.op = op; e.ill = ill; e.psr = psr; e.a = old_v; e.b = b;
    e.old_v = old_v; e.new_v = new_v; e.cyc = cyc + 2;
    q.push_back(e);
    @(negedge clk);
    if (hold > 1) begin
      bus.op_code = 8'd3;
      bus.imm     = 8'h07;
      repeat (hold - 1) @(negedge clk);
    end
    bus.op_valid = 1'b0;
    wait_ready("retire_wait");
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_psr"}, 32'(bus.psr), 32'h0);
    chk({tag, "_op_ready"}, 32'(bus.op_ready), 32'h1);
    chk({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd24);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      chk({tag, "_dbg_sweep"}, 32'(bus.dbg_data), 32'h0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no retire pending");
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("illegal", 32'(bus.illegal), 32'(e.ill));
          chk("op_ready_busy", 32'(bus.op_ready), 32'h0);
          chk("alu_a", 32'(bus.alu_a), 32'(e.a));
          chk("alu_b", 32'(bus.alu_b), 32'(e.b));
          chk("alu_opcode", 32'(bus.alu_opcode), 32'(e.op));
          chk("dbg_old", 32'(bus.dbg_data), 32'(e.old_v));
          @(posedge clk);
          #1;
          chk("psr", 32'(bus.psr), 32'(e.psr));
          chk("dbg_new", 32'(bus.dbg_data), 32'(e.new_v));
          chk("done_pulse", 32'(bus.done), 32'h0);
          chk("illegal_pulse", 32'(bus.illegal), 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 8'd0;
    bus.rdest    = 4'd0;
    bus.rsrc     = 4'd0;
    bus.imm      = 8'd0;
    bus.dbg_addr = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_checks("reset");

    //     op     rd    rs    imm    ill   psr     alu_b     old       new      hold
    issue(8'd2,  4'd1, 4'd0, 8'hFF, 1'b0, 5'h00, 16'hFFFF, 16'h0000, 16'hFFFF, 1); // ADDI
    issue(8'd21, 4'd1, 4'd0, 8'h01, 1'b0, 5'h00, 16'h0001, 16'hFFFF, 16'h7FFF, 1); // RSHI
    issue(8'd3,  4'd2, 4'd0, 8'h01, 1'b0, 5'h00, 16'h0001, 16'h0000, 16'h0001, 1); // ADDUI
    issue(8'd0,  4'd1, 4'd2, 8'h00, 1'b0, 5'h02, 16'h0001, 16'h7FFF, 16'h8000, 1); // ADD
    issue(8'd2,  4'd3, 4'd0, 8'hFF, 1'b0, 5'h00, 16'hFFFF, 16'h0000, 16'hFFFF, 1); // ADDI
    issue(8'd3,  4'd4, 4'd0, 8'h05, 1'b0, 5'h00, 16'h0005, 16'h0000, 16'h0005, 1); // ADDUI
    issue(8'd3,  4'd3, 4'd0, 8'h01, 1'b0, 5'h11, 16'h0001, 16'hFFFF, 16'h0000, 1); // ADDUI
    issue(8'd9,  4'd4, 4'd0, 8'hFF, 1'b0, 5'h01, 16'hFFFF, 16'h0005, 16'h0006, 1); // SUBI
    issue(8'd13, 4'd4, 4'd0, 8'h80, 1'b0, 5'h05, 16'h0080, 16'h0006, 16'h0006, 1); // CMPUI
    issue(8'd12, 4'd4, 4'd0, 8'h80, 1'b0, 5'h01, 16'hFF80, 16'h0006, 16'h0006, 1); // CMPI
    issue(8'd30, 4'd4, 4'd3, 8'h00, 1'b1, 5'h01, 16'h0000, 16'h0006, 16'h0006, 3); // bad op
    issue(8'd7,  4'd4, 4'd4, 8'h10, 1'b1, 5'h01, 16'h0006, 16'h0006, 16'h0006, 1); // ADDCI
    issue(8'd24, 4'd4, 4'd2, 8'h00, 1'b0, 5'h01, 16'h0001, 16'h0006, 16'h0006, 1); // NOP
    issue(8'd0,  4'd2, 4'd2, 8'h00, 1'b0, 5'h01, 16'h0001, 16'h0001, 16'h0002, 1); // ADD same
    issue(8'd18, 4'd2, 4'd2, 8'h00, 1'b0, 5'h01, 16'h0002, 16'h0002, 16'h0008, 1); // LSH
    issue(8'd25, 4'd2, 4'd0, 8'h00, 1'b1, 5'h01, 16'h0000, 16'h0008, 16'h0008, 1); // first >24

    // AND R1,R4 aborted by reset while in EXEC
    @(negedge clk);
    bus.op_code  = 8'd14;
    bus.rdest    = 4'd1;
    bus.rsrc     = 4'd4;
    bus.op_valid = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_checks("abort");
    repeat (4) @(negedge clk);

    issue(8'd3,  4'd0, 4'd0, 8'h05, 1'b0, 5'h00, 16'h0005, 16'h0000, c_R0_NEW, 1); // ADDUI R0

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
